// File: rtl/vliw_issue_queue.sv
// Circular-buffer issue queue for VLIW bundles, first-word-fall-through head
// with per-lane NOP detection and opcode extraction.
module vliw_issue_queue #(
  parameter int CORES    = 4,
  parameter int INST_LEN = 32,
  parameter int DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INST_LEN*CORES-1:0]     vliw_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INST_LEN*CORES-1:0]     out_inst,
  output logic [CORES-1:0]              out_lane_valid,
  output logic [6*CORES-1:0]            out_op,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          drop_err
);

  localparam int W  = INST_LEN * CORES;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dropErr_q, dropErr_d;
  logic          push, pop;
  logic [W-1:0]  headInst;

  // Readiness comes only from the registered count, so out_ready never feeds in_ready.
  assign in_ready  = (count_q < FullCount);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign drop_err  = dropErr_q;

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    dropErr_d = dropErr_q;
    if (flush) begin
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      count_d   = '0;
      dropErr_d = 1'b0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (in_valid && !in_ready) dropErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      dropErr_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      dropErr_q <= dropErr_d;
    end
  end

  // Entry storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wrPtr_q] <= vliw_in;
  end

  assign headInst = out_valid ? mem_q[rdPtr_q] : '0;
  assign out_inst = headInst;

  always_comb begin
    out_lane_valid = '0;
    out_op         = '0;
    for (int i = 0; i < CORES; i++) begin
      out_lane_valid[i] = |headInst[i*INST_LEN +: INST_LEN];
      out_op[6*i +: 6]  = headInst[i*INST_LEN + INST_LEN - 6 +: 6];
    end
  end

endmodule

// File: tb/tb_vliw_issue_queue.sv
// Scoreboard bench for vliw_issue_queue: accepted bundles are queued as the
// expected head sequence and compared as the DUT presents them.
module tb_vliw_issue_queue;

  localparam int CORES    = 4;
  localparam int INST_LEN = 32;
  localparam int DEPTH    = 4;
  localparam int W        = CORES * INST_LEN;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic [W-1:0]     vliwIn;
  logic             inValid;
  logic             inReady;
  logic             flush;
  logic             outValid;
  logic             outReady;
  logic [W-1:0]     outInst;
  logic [CORES-1:0] outLaneValid;
  logic [6*CORES-1:0] outOp;
  logic [CW-1:0]    count;
  logic             dropErr;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] sbq[$];
  bit           mDrop;

  vliw_issue_queue #(.CORES(CORES), .INST_LEN(INST_LEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .vliw_in(vliwIn), .in_valid(inValid), .in_ready(inReady),
    .flush(flush), .out_valid(outValid), .out_ready(outReady), .out_inst(outInst),
    .out_lane_valid(outLaneValid), .out_op(outOp), .count(count), .drop_err(dropErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: the run must always terminate.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [W-1:0] randBundle();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock edge and update the reference model with what the edge should do.
  task automatic tick();
    bit accept, consume;
    accept  = inValid && (sbq.size() < DEPTH);
    consume = outReady && (sbq.size() > 0);
    if (flush) begin
      sbq.delete();
      mDrop = 1'b0;
    end else begin
      if (inValid && !accept) mDrop = 1'b1;
      if (consume) void'(sbq.pop_front());
      if (accept) sbq.push_back(vliwIn);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; inValid = 1'b0; outReady = 1'b0; flush = 1'b0; vliwIn = '0;
    sbq.delete(); mDrop = 1'b0;
    #1;
    vectors++;
    if (count !== '0 || inReady !== 1'b1 || outValid !== 1'b0 || dropErr !== 1'b0 || outInst !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: count=%0d in_ready=%b out_valid=%b drop_err=%b, required 0/1/0/0",
               count, inReady, outValid, dropErr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (count !== '0 || inReady !== 1'b1 || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: count=%0d in_ready=%b out_valid=%b, required 0/1/0",
               count, inReady, outValid);
    end
  endtask

  task automatic test_single_push();
    vliwIn  = 128'h00000000_8C220004_00000000_20010005;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    vectors++;
    if (outValid !== 1'b1 || count !== CW'(1)) begin
      miscompares++;
      $display("[TB] FAIL single_push_valid: out_valid=%b count=%0d, required 1/1", outValid, count);
    end
    vectors++;
    if (outLaneValid !== 4'b0101) begin
      miscompares++;
      $display("[TB] FAIL single_push_lanes: got %b required 0101", outLaneValid);
    end
    vectors++;
    if (outOp !== 24'h023008) begin
      miscompares++;
      $display("[TB] FAIL single_push_ops: got %h required 023008", outOp);
    end
    vectors++;
    if (outInst !== sbq[0]) begin
      miscompares++;
      $display("[TB] FAIL single_push_inst: got %h required %h", outInst, sbq[0]);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    vectors++;
    if (outValid !== 1'b0 || count !== '0 || outInst !== '0 || outOp !== '0 || outLaneValid !== '0) begin
      miscompares++;
      $display("[TB] FAIL single_pop_empty: out_valid=%b count=%0d inst=%h op=%h lanes=%b, required all zero",
               outValid, count, outInst, outOp, outLaneValid);
    end
  endtask

  task automatic test_full_drop();
    logic [W-1:0] dropped;
    outReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      vliwIn  = randBundle();
      inValid = 1'b1;
      tick();
    end
    vectors++;
    if (count !== CW'(DEPTH) || inReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_state: count=%0d in_ready=%b, required %0d/0", count, inReady, DEPTH);
    end
    dropped = randBundle();
    vliwIn  = dropped;
    tick();
    inValid = 1'b0;
    vectors++;
    if (dropErr !== mDrop || dropErr !== 1'b1 || count !== CW'(DEPTH)) begin
      miscompares++;
      $display("[TB] FAIL full_drop: drop_err=%b count=%0d, required 1/%0d", dropErr, count, DEPTH);
    end
    outReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (outValid !== 1'b1 || outInst !== sbq[0] || outInst === dropped) begin
        miscompares++;
        $display("[TB] FAIL full_pop_%0d: valid=%b got %h required %h", i, outValid, outInst, sbq[0]);
      end
      tick();
    end
    outReady = 1'b0;
    vectors++;
    if (count !== '0 || outValid !== 1'b0 || dropErr !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_drained: count=%0d out_valid=%b drop_err=%b, required 0/0/1",
               count, outValid, dropErr);
    end
  endtask

  task automatic test_back_to_back();
    outReady = 1'b0;
    inValid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vliwIn = randBundle();
      tick();
    end
    outReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vliwIn = randBundle();
      vectors++;
      if (outInst !== sbq[0]) begin
        miscompares++;
        $display("[TB] FAIL b2b_order_%0d: got %h required %h", i, outInst, sbq[0]);
      end
      tick();
      vectors++;
      if (count !== CW'(2)) begin
        miscompares++;
        $display("[TB] FAIL b2b_count_%0d: got %0d required 2", i, count);
      end
    end
    inValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (outInst !== sbq[0]) begin
        miscompares++;
        $display("[TB] FAIL b2b_drain_%0d: got %h required %h", i, outInst, sbq[0]);
      end
      tick();
    end
    outReady = 1'b0;
    vectors++;
    if (count !== '0 || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_empty: count=%0d out_valid=%b, required 0/0", count, outValid);
    end
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    inValid  = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      vliwIn = randBundle();
      tick();
    end
    vectors++;
    if (count !== CW'(DEPTH) || dropErr !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_setup: count=%0d drop_err=%b, required %0d/1", count, dropErr, DEPTH);
    end
    flush    = 1'b1;
    outReady = 1'b1;
    vliwIn   = randBundle();
    tick();
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    vectors++;
    if (count !== '0 || dropErr !== 1'b0 || outValid !== 1'b0 || inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_result: count=%0d drop_err=%b out_valid=%b in_ready=%b, required 0/0/0/1",
               count, dropErr, outValid, inReady);
    end
    vliwIn  = randBundle();
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    vectors++;
    if (count !== CW'(1) || outInst !== sbq[0]) begin
      miscompares++;
      $display("[TB] FAIL flush_repush: count=%0d got %h required 1 / %h", count, outInst, sbq[0]);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  task automatic test_async_reset();
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vliwIn = randBundle();
      tick();
    end
    inValid = 1'b0;
    vectors++;
    if (count !== CW'(3)) begin
      miscompares++;
      $display("[TB] FAIL areset_setup: count=%0d required 3", count);
    end
    #2;
    reset = 1'b1;
    #1;
    sbq.delete();
    mDrop = 1'b0;
    vectors++;
    if (count !== '0 || outValid !== 1'b0 || inReady !== 1'b1 || outInst !== '0 ||
        outOp !== '0 || outLaneValid !== '0 || dropErr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL areset_immediate: count=%0d valid=%b ready=%b inst=%h, required 0/0/1/0",
               count, outValid, inReady, outInst);
    end
    #1;
    reset   = 1'b0;
    vliwIn  = randBundle();
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    vectors++;
    if (count !== CW'(1) || outValid !== 1'b1 || outInst !== sbq[0]) begin
      miscompares++;
      $display("[TB] FAIL areset_push: count=%0d valid=%b got %h required 1/1/%h",
               count, outValid, outInst, sbq[0]);
    end
  endtask

  initial begin
    $display("[TB] starting vliw_issue_queue bench");
    test_reset();
    test_single_push();
    test_full_drop();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
